// File: rtl/layer4_maxpool_ctrl.sv
// 2x2 max-pool scanner over the layer-3 result memory.
// Emits one lane-wise signed-max word per window, row-major.
module layer4_maxpool_ctrl #(
  parameter int DATA_W   = 128,
  parameter int LANE_W   = 16,
  parameter int IN_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_read_signal,
  output logic [15:0]       read_row_addr,
  output logic [15:0]       read_col_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       out_row,
  output logic [15:0]       out_col
);

  localparam int LANES = DATA_W / LANE_W;
  localparam logic [15:0] LAST = 16'(IN_WIDTH / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state, state_nx;
  logic [15:0] wr, wr_nx;
  logic [15:0] wc, wc_nx;
  logic [DATA_W-1:0] acc, acc_nx;
  logic [DATA_W-1:0] max_w;
  logic [15:0] row0, col0;

  assign row0 = wr << 1;
  assign col0 = wc << 1;

  // Ties keep the accumulator lane; lanes never interact.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [LANE_W-1:0] a, b;
    assign a = acc[g*LANE_W +: LANE_W];
    assign b = mem_rdata[g*LANE_W +: LANE_W];
    assign max_w[g*LANE_W +: LANE_W] = (b > a) ? b : a;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      wr    <= '0;
      wc    <= '0;
      acc   <= '0;
    end else begin
      state <= state_nx;
      wr    <= wr_nx;
      wc    <= wc_nx;
      acc   <= acc_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    wr_nx           = wr;
    wc_nx           = wc;
    acc_nx          = acc;
    busy            = (state != S_IDLE);
    done            = 1'b0;
    mem_read_signal = 1'b0;
    read_row_addr   = '0;
    read_col_addr   = '0;
    out_valid       = 1'b0;
    out_data        = '0;
    out_row         = '0;
    out_col         = '0;
    unique case (state)
      S_IDLE: begin
        wr_nx = '0;
        wc_nx = '0;
        if (start) state_nx = S_RD0;
      end
      S_RD0: begin
        mem_read_signal = 1'b1;
        read_row_addr   = row0;
        read_col_addr   = col0;
        acc_nx          = mem_rdata;
        state_nx        = S_RD1;
      end
      S_RD1: begin
        mem_read_signal = 1'b1;
        read_row_addr   = row0;
        read_col_addr   = col0 | 16'd1;
        acc_nx          = max_w;
        state_nx        = S_RD2;
      end
      S_RD2: begin
        mem_read_signal = 1'b1;
        read_row_addr   = row0 | 16'd1;
        read_col_addr   = col0;
        acc_nx          = max_w;
        state_nx        = S_RD3;
      end
      S_RD3: begin
        mem_read_signal = 1'b1;
        read_row_addr   = row0 | 16'd1;
        read_col_addr   = col0 | 16'd1;
        acc_nx          = max_w;
        state_nx        = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        out_data  = acc;
        out_row   = wr;
        out_col   = wc;
        if (out_ready) begin
          if (wc < LAST) begin
            wc_nx    = wc + 16'd1;
            state_nx = S_RD0;
          end else begin
            wc_nx = '0;
            if (wr < LAST) begin
              wr_nx    = wr + 16'd1;
              state_nx = S_RD0;
            end else begin
              state_nx = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_layer4_maxpool_ctrl.sv
// Randomized bench for layer4_maxpool_ctrl against a
// set-maximum reference computed from a memory image.
module tb_layer4_maxpool_ctrl;

  localparam int N = 8;
  localparam int H = N / 2;
  localparam int LANES = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         busy;
  logic         done;
  logic         mem_read_signal;
  logic [15:0]  read_row_addr;
  logic [15:0]  read_col_addr;
  logic [127:0] mem_rdata;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [15:0]  out_row;
  logic [15:0]  out_col;

  logic [127:0] mem [N][N];

  int total, bad;
  int cyc, nout, nrd, ndone, done_cyc;
  bit formula;
  logic [127:0] first_word;

  layer4_maxpool_ctrl #(
    .DATA_W(128),
    .LANE_W(16),
    .IN_WIDTH(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .mem_read_signal(mem_read_signal),
    .read_row_addr(read_row_addr),
    .read_col_addr(read_col_addr),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_row(out_row),
    .out_col(out_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mem_rdata = '0;
    if (mem_read_signal && read_row_addr < 16'(N) && read_col_addr < 16'(N))
      mem_rdata = mem[read_row_addr[2:0]][read_col_addr[2:0]];
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pool(int i, int j);
    logic [127:0] r, w;
    logic [15:0] raw;
    int best, v;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      best = -1000000;
      for (int k = 0; k < 4; k++) begin
        w = mem[2*i + k/2][2*j + k%2];
        raw = w[l*16 +: 16];
        v = int'($signed(raw));
        if (v > best) best = v;
      end
      r[l*16 +: 16] = 16'(best);
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_lane();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        for (int l = 0; l < LANES; l++)
          mem[r][c][l*16 +: 16] = rand_lane();
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mem[r][c] = {LANES{16'(16*r + c)}};
  endtask

  task automatic zero_check(input string tag);
    check({tag, "_ctl"},
          {busy, done, out_valid, mem_read_signal,
           read_row_addr, read_col_addr, out_row, out_col}, '0);
    check({tag, "_data"}, out_data, '0);
  endtask

  // Observe the current cycle, then advance past the next edge.
  task automatic cycle();
    if (mem_read_signal) begin
      check("rd_addr", {read_row_addr, read_col_addr},
            {16'(2*(nout/H) + nrd/2), 16'(2*(nout%H) + nrd%2)});
      nrd++;
    end
    if (out_valid) check("rd_count", nrd, 4);
    if (out_valid && out_ready) begin
      check("out_row", out_row, nout / H);
      check("out_col", out_col, nout % H);
      check("out_data", out_data, pool(nout / H, nout % H));
      if (formula)
        check("ramp_lane", out_data[15:0],
              16*(2*(nout/H) + 1) + 2*(nout%H) + 1);
      if (nout == 0) first_word = out_data;
      nout++;
      nrd = 0;
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // pol: 0 ready high, 1 random ready, 2 stall 7 cycles at (1,2)
  task automatic run_scan(input int pol, input bit form, input bit extra);
    int budget, stall_n;
    bit held;
    logic [127:0] hd;
    logic [15:0] hr, hc;
    formula = form;
    nout = 0;
    nrd = 0;
    ndone = 0;
    done_cyc = 0;
    stall_n = 0;
    held = 0;
    hd = '0;
    hr = '0;
    hc = '0;
    start = 1'b1;
    out_ready = 1'b0;
    cycle();
    start = 1'b0;
    cyc = 1;
    check("busy_start", busy, 1);
    budget = 0;
    while (ndone == 0 && budget < 2000) begin
      start = extra && (cyc == 10 || cyc == 40 || done);
      case (pol)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(out_valid && nout == 6 && stall_n < 7);
      endcase
      if (out_valid && !out_ready) begin
        stall_n++;
        check("stall_rd", mem_read_signal, 0);
        if (held) check("stall_hold", {out_data, out_row, out_col},
                        {hd, hr, hc});
        hd = out_data;
        hr = out_row;
        hc = out_col;
        held = 1;
      end else begin
        held = 0;
      end
      cycle();
      budget++;
    end
    start = 1'b0;
    check("done_once", ndone, 1);
    check("n_out", nout, 16);
    if (form) check("done_cycle", done_cyc, 81);
    if (pol == 2) check("stall_len", stall_n, 7);
    check("idle_after", {busy, done}, 0);
  endtask

  task automatic reset_mid_scan();
    int budget;
    formula = 0;
    nout = 0;
    nrd = 0;
    ndone = 0;
    start = 1'b1;
    out_ready = 1'b1;
    cycle();
    start = 1'b0;
    cyc = 1;
    budget = 0;
    while (!(mem_read_signal && nout == 9 && nrd == 2) && budget < 200) begin
      cycle();
      budget++;
    end
    check("rst_reach", budget < 200, 1);
    #2 rst = 1'b1;
    #1 zero_check("rst_async");
    @(negedge clk);
    zero_check("rst_hold");
    check("rst_nodone", ndone, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    formula = 0;
    first_word = '0;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    fill_random();
    #3 zero_check("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 zero_check("idle");

    fill_random();
    mem[0][0][31:0] = {16'hFFF0, 16'h0005};
    mem[0][1][31:0] = {16'hFFF1, 16'hFFFF};
    mem[1][0][31:0] = {16'hFFF0, 16'h7FFF};
    mem[1][1][31:0] = {16'hFFF2, 16'h8000};
    run_scan(1, 0, 0);
    check("smax_lane0", first_word[15:0], 16'h7FFF);
    check("smax_lane1", first_word[31:16], 16'hFFF2);

    fill_ramp();
    run_scan(0, 1, 0);

    fill_random();
    run_scan(2, 0, 0);

    fill_random();
    run_scan(0, 0, 1);

    fill_random();
    reset_mid_scan();
    run_scan(1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
